// File: rtl/arccos_bisect.sv
// arccos_bisect: sequential Q16 inverse cosine.
// Bisects [0, HALF_PI] using cos(mid) from an 8th-order Horner Taylor series.
// All multiplies share one radix-2 shift-add unit (17 add steps plus 1 writeback).
module arccos_bisect #(
   parameter int ITER    = 17,
   parameter int HALF_PI = 102944
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [16:0] y_in,
   output logic        busy,
   output logic        done,
   output logic [16:0] angle,
   output logic        sat
);

   // S_ARM is the launch cycle after acceptance; busy becomes visible as it is left.
   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_MID,
      S_MUL,
      S_CMP,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [16:0] y_q, y_d;
   logic        sat_next_q, sat_next_d;
   logic [16:0] lo_q, lo_d;
   logic [16:0] hi_q, hi_d;
   logic [16:0] mid_q, mid_d;
   logic [16:0] t_q, t_d;
   // z = mid^2 reaches (pi/2)^2 ~ 2.47 in Q16, so it needs one bit more than 17.
   logic [17:0] z_q, z_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [3:0]  mstep_q, mstep_d;
   logic [4:0]  mcyc_q, mcyc_d;
   logic [33:0] ma_q, ma_d;
   logic [16:0] mb_q, mb_d;
   logic [33:0] acc_q, acc_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [16:0] angle_q, angle_d;
   logic        sat_q, sat_d;
   logic [17:0] res;

   // Horner coefficients 1/56, 1/30, 1/12, 1/2 in Q16, innermost first.
   function automatic logic [16:0] coef(input logic [1:0] k);
      case (k)
         2'd0:    coef = 17'd1170;
         2'd1:    coef = 17'd2185;
         2'd2:    coef = 17'd5461;
         default: coef = 17'd32768;
      endcase
   endfunction

   // Next-state logic for the bisection controller and the shared multiplier.
   always_comb begin
      state_d    = state_q;
      y_d        = y_q;
      sat_next_d = sat_next_q;
      lo_d       = lo_q;
      hi_d       = hi_q;
      mid_d      = mid_q;
      t_d        = t_q;
      z_d        = z_q;
      cnt_d      = cnt_q;
      mstep_d    = mstep_q;
      mcyc_d     = mcyc_q;
      ma_d       = ma_q;
      mb_d       = mb_q;
      acc_d      = acc_q;
      angle_d    = angle_q;
      sat_d      = sat_q;
      busy_d     = (state_q != S_IDLE) && (state_q != S_DONE);
      done_d     = (state_q == S_DONE);
      res        = acc_q[33:16];

      case (state_q)
         S_IDLE: begin
            // A start coinciding with the done pulse is dropped on purpose.
            if (start && !done_q) begin
               sat_next_d = (y_in > 17'd65536);
               y_d        = (y_in > 17'd65536) ? 17'd65536 : y_in;
               lo_d       = '0;
               hi_d       = 17'(HALF_PI);
               cnt_d      = '0;
               state_d    = S_ARM;
            end
         end
         S_ARM: begin
            state_d = S_MID;
         end
         S_MID: begin
            mid_d   = 17'(({1'b0, lo_q} + {1'b0, hi_q}) >> 1);
            t_d     = 17'd65536;
            ma_d    = {17'd0, mid_d};
            mb_d    = mid_d;
            acc_d   = '0;
            mcyc_d  = '0;
            mstep_d = '0;
            state_d = S_MUL;
         end
         S_MUL: begin
            if (mcyc_q != 5'd17) begin
               if (mb_q[0]) begin
                  acc_d = acc_q + ma_q;
               end
               ma_d   = ma_q << 1;
               mb_d   = mb_q >> 1;
               mcyc_d = mcyc_q + 5'd1;
            end else begin
               // Writeback: step 0 yields z, odd steps yield w, even steps yield p.
               if (mstep_q == 4'd0) begin
                  z_d = res;
               end else if (mstep_q[0] == 1'b0) begin
                  t_d = (res >= 18'd65536) ? 17'd0 : (17'd65536 - res[16:0]);
               end
               acc_d  = '0;
               mcyc_d = '0;
               if (mstep_q == 4'd8) begin
                  state_d = S_CMP;
               end else begin
                  mstep_d = mstep_q + 4'd1;
                  if (mstep_q[0] == 1'b0) begin
                     // Next is w = z * c.
                     ma_d = {16'd0, (mstep_q == 4'd0) ? res : z_q};
                     mb_d = coef(mstep_d[2:1]);
                  end else begin
                     // Next is p = w * t, w being the value just produced.
                     ma_d = {16'd0, res};
                     mb_d = t_q;
                  end
               end
            end
         end
         S_CMP: begin
            if (t_q > y_q) begin
               lo_d = mid_q;
            end else begin
               hi_d = mid_q;
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_d == 5'(ITER)) begin
               state_d = S_DONE;
            end else begin
               state_d = S_MID;
            end
         end
         S_DONE: begin
            angle_d = lo_q;
            sat_d   = sat_next_q;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset aborts any request without a done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         y_q        <= '0;
         sat_next_q <= 1'b0;
         lo_q       <= '0;
         hi_q       <= '0;
         mid_q      <= '0;
         t_q        <= '0;
         z_q        <= '0;
         cnt_q      <= '0;
         mstep_q    <= '0;
         mcyc_q     <= '0;
         ma_q       <= '0;
         mb_q       <= '0;
         acc_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         angle_q    <= '0;
         sat_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         y_q        <= y_d;
         sat_next_q <= sat_next_d;
         lo_q       <= lo_d;
         hi_q       <= hi_d;
         mid_q      <= mid_d;
         t_q        <= t_d;
         z_q        <= z_d;
         cnt_q      <= cnt_d;
         mstep_q    <= mstep_d;
         mcyc_q     <= mcyc_d;
         ma_q       <= ma_d;
         mb_q       <= mb_d;
         acc_q      <= acc_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         angle_q    <= angle_d;
         sat_q      <= sat_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign angle = angle_q;
   assign sat   = sat_q;

endmodule

// File: tb/tb_arccos_bisect.sv
// Testbench for arccos_bisect: directed vectors plus a real-valued acos model,
// with a per-cycle monitor for busy/done timing, result accuracy and output hold.
module tb_arccos_bisect;

   localparam int LAT = 2790; // 17 iterations * 164 + 2

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [16:0] y_in;
   logic        busy;
   logic        done;
   logic [16:0] angle;
   logic        sat;

   always #5 clk = ~clk;

   arccos_bisect dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .y_in  (y_in),
      .busy  (busy),
      .done  (done),
      .angle (angle),
      .sat   (sat)
   );

   int          n_assert = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          acc_edge = -1;
   int          exp_y    = 0;
   int          done_cnt = 0;
   logic [16:0] held_angle = '0;
   logic        held_sat   = 1'b0;
   logic        chk_en     = 1'b0;
   logic        eb, ed;
   int          ya, rr, dd;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input bit ok, input longint act, input longint req);
      n_assert++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: nearest Q16 value of acos(y/65536).
   function automatic int ref_angle(input int yv);
      real r;
      r = $acos(real'(yv) / 65536.0) * 65536.0;
      return int'(r);
   endfunction

   // Monitor: timing of busy/done from the accepting edge, result on done, hold otherwise.
   always @(negedge clk) begin
      if (!rst && chk_en) begin
         eb = (acc_edge >= 0) && (cyc >= acc_edge + 1) && (cyc <= acc_edge + LAT - 1);
         ed = (acc_edge >= 0) && (cyc == acc_edge + LAT);
         if (done) done_cnt++;
         check("busy", busy == eb, busy, eb);
         check("done", done == ed, done, ed);
         if (ed) begin
            ya = (exp_y > 65536) ? 65536 : exp_y;
            check("sat", sat == (exp_y > 65536), sat, exp_y > 65536);
            if (ya >= 65536) begin
               check("angle_at_one", angle == 17'd0, angle, 0);
            end else if (ya <= 64880) begin
               rr = ref_angle(ya);
               dd = int'(angle) - rr;
               check("angle_acc", (dd <= 64) && (dd >= -64), angle, rr);
            end
            held_angle = angle;
            held_sat   = sat;
         end else begin
            check("angle_hold", angle == held_angle, angle, held_angle);
            check("sat_hold", sat == held_sat, sat, held_sat);
         end
      end
   end

   task automatic launch(input int yv);
      @(negedge clk);
      y_in     = yv[16:0];
      start    = 1'b1;
      exp_y    = yv;
      acc_edge = cyc + 1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run(input int yv, output int ang);
      bit found;
      found = 1'b0;
      launch(yv);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (done) begin
            found = 1'b1;
            break;
         end
      end
      check("done_seen", found, found, 1);
      check("latency", (cyc - acc_edge) == LAT, cyc - acc_edge, LAT);
      ang = int'(angle);
      $display("y_in=%0d angle=%0d sat=%0d ref=%0d", yv, angle, sat,
               ref_angle((yv > 65536) ? 65536 : yv));
      @(negedge clk);
   endtask

   initial begin
      int a;
      int ea;
      int dc0;
      rst   = 1'b1;
      start = 1'b0;
      y_in  = '0;

      // Model pins.
      check("ref_half", ref_angle(32768) == 68629, ref_angle(32768), 68629);
      check("ref_rt2", ref_angle(46341) == 51472, ref_angle(46341), 51472);
      check("ref_zero", ref_angle(0) == 102944, ref_angle(0), 102944);

      repeat (3) @(negedge clk);
      check("rst_busy", busy == 1'b0, busy, 0);
      check("rst_done", done == 1'b0, done, 0);
      check("rst_angle", angle == 17'd0, angle, 0);
      check("rst_sat", sat == 1'b0, sat, 0);
      rst    = 1'b0;
      chk_en = 1'b1;

      run(32768, a);
      check("half_angle", (a >= 68629 - 64) && (a <= 68629 + 64), a, 68629);
      check("half_sat", sat == 1'b0, sat, 0);

      // Abort a request mid-run.
      launch(12345);
      repeat (1000) @(negedge clk);
      #2;
      rst        = 1'b1;
      acc_edge   = -1;
      held_angle = '0;
      held_sat   = 1'b0;
      @(negedge clk);
      check("abort_busy", busy == 1'b0, busy, 0);
      check("abort_done", done == 1'b0, done, 0);
      check("abort_angle", angle == 17'd0, angle, 0);
      rst = 1'b0;
      repeat (50) @(negedge clk);
      $display("aborted request at cycle 1000, reset released");

      run(32768, a);
      check("half_again", (a >= 68629 - 64) && (a <= 68629 + 64), a, 68629);

      run(46341, a);
      check("rt2_angle", (a >= 51472 - 64) && (a <= 51472 + 64), a, 51472);

      run(0, a);
      check("zero_angle", (a >= 102941) && (a <= 102943), a, 102942);

      run(65536, a);
      check("one_angle", a == 0, a, 0);
      check("one_sat", sat == 1'b0, sat, 0);

      run(70000, a);
      check("clamp_angle", a == 0, a, 0);
      check("clamp_sat", sat == 1'b1, sat, 1);

      // Extra starts while busy and together with done are ignored.
      dc0 = done_cnt;
      launch(32768);
      ea = acc_edge;
      while (cyc < ea + 4) @(negedge clk);
      y_in  = 17'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (cyc < ea + LAT) @(negedge clk);
      y_in  = 17'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      check("hs_one_done", (done_cnt - dc0) == 1, done_cnt - dc0, 1);
      check("hs_idle", busy == 1'b0, busy, 0);
      check("hs_angle", (int'(angle) >= 68629 - 64) && (int'(angle) <= 68629 + 64), angle, 68629);
      $display("handshake run: dones=%0d angle=%0d", done_cnt - dc0, angle);

      // Back-to-back random values; monitor checks accuracy and timing.
      for (int k = 0; k < 12; k++) begin
         run(int'($urandom_range(0, 64880)), a);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
